// File: rtl/player_pkg.sv
// Shared definitions for the music player front end: button bit indices,
// the default auto-repeat mask and the per-button conditioner state encoding.
package player_pkg;

  localparam int BTN_PLAY_PAUSE = 0;
  localparam int BTN_PASS_10S   = 1;
  localparam int BTN_BACK_10S   = 2;
  localparam int BTN_PASS_30S   = 3;
  localparam int BTN_BACK_30S   = 4;
  localparam int BTN_NEXT_SONG  = 5;
  localparam int BTN_PREV_SONG  = 6;
  localparam int BTN_VOL_UP     = 7;
  localparam int BTN_VOL_DOWN   = 8;
  localparam int BTN_MUTE       = 9;
  localparam int BTN_SPARE      = 10;

  localparam int N_BTN_DEFAULT = 11;

  // Only the volume buttons auto-repeat while held.
  localparam logic [N_BTN_DEFAULT-1:0] BTN_REPEAT_DEFAULT =
    (N_BTN_DEFAULT'(1) << BTN_VOL_UP) | (N_BTN_DEFAULT'(1) << BTN_VOL_DOWN);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } btn_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button lane: 2-flop synchronizer, stable-count debouncer and a
// press/hold-to-repeat FSM producing single-cycle strobes.
module button_channel
  import player_pkg::*;
#(
  parameter bit REPEAT_EN       = 1'b0,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_pulse,
  output logic pulse_next
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  btn_state_e       state_q, state_d;
  logic             level_rise, level_fall;
  logic             delay_term, period_term;

  always_comb begin
    s1_d    = btn_raw;
    s2_d    = s1_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    if (s2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = s2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    level_rise = level_d & ~level_q;
    level_fall = ~level_d & level_q;
  end

  // The FSM looks at level_d so the press strobe lands in the same cycle
  // the debounced level first reads high.
  always_comb begin
    state_d = state_q;
    pulse_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (level_rise) begin
          state_d = ST_HELD;
          pulse_d = 1'b1;
        end
      end
      ST_HELD: begin
        if (level_fall) begin
          state_d = ST_IDLE;
        end else if (REPEAT_EN && delay_term) begin
          state_d = ST_REPEAT;
          pulse_d = 1'b1;
        end
      end
      ST_REPEAT: begin
        if (level_fall) begin
          state_d = ST_IDLE;
        end else if (period_term) begin
          pulse_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  generate
    if (REPEAT_EN) begin : g_repeat
      localparam int RCNT_W = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD));

      logic [RCNT_W-1:0] rcnt_q, rcnt_d;

      // Any strobe restarts the interval; IDLE keeps the counter parked at 0.
      always_comb begin
        if (state_q == ST_IDLE || pulse_d) begin
          rcnt_d = '0;
        end else begin
          rcnt_d = rcnt_q + RCNT_W'(1);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rcnt_q <= '0;
        end else begin
          rcnt_q <= rcnt_d;
        end
      end

      assign delay_term  = (rcnt_q == RCNT_W'(REPEAT_DELAY - 1));
      assign period_term = (rcnt_q == RCNT_W'(REPEAT_PERIOD - 1));
    end else begin : g_no_repeat
      assign delay_term  = 1'b0;
      assign period_term = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      state_q <= ST_IDLE;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      state_q <= state_d;
    end
  end

  assign btn_level  = level_q;
  assign btn_pulse  = pulse_q;
  assign pulse_next = pulse_d;

endmodule

// File: rtl/button_conditioner.sv
// Push-button front end for the Player: an independent conditioning lane per
// button plus a registered any-button strobe aligned with btn_pulse.
module button_conditioner
  import player_pkg::*;
#(
  parameter int               N_BTN           = 11,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               REPEAT_DELAY    = 25000000,
  parameter int               REPEAT_PERIOD   = 5000000,
  parameter logic [N_BTN-1:0] REPEAT_MASK     = N_BTN'(BTN_REPEAT_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic             any_pulse
);

  logic [N_BTN-1:0] pulse_next;
  logic             any_pulse_q, any_pulse_d;

  generate
    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      button_channel #(
        .REPEAT_EN       (REPEAT_MASK[i]),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_ch (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn_raw[i]),
        .btn_level  (btn_level[i]),
        .btn_pulse  (btn_pulse[i]),
        .pulse_next (pulse_next[i])
      );
    end
  endgenerate

  // OR the lanes' next-pulse terms so any_pulse registers alongside btn_pulse.
  always_comb begin
    any_pulse_d = |pulse_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_pulse_q <= 1'b0;
    end else begin
      any_pulse_q <= any_pulse_d;
    end
  end

  assign any_pulse = any_pulse_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed scenarios with literal
// timing expectations plus randomized bouncy stimulus against a window model.
module tb_button_conditioner;
  import player_pkg::*;

  localparam int NB  = 11;
  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RP  = 5;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] btn_raw = '0;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_pulse;
  logic          any_pulse;

  always #5 clk = ~clk;

  button_conditioner #(
    .N_BTN           (NB),
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .btn_pulse (btn_pulse),
    .any_pulse (any_pulse)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
  endtask

  task automatic check_log(input string name, input int got[$], input int exp[$]);
    check({name, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s_%0d", name, i), got[i], exp[i]);
  endtask

  // Reference model: level flips once the last DEB synchronized samples all
  // disagree with it; pulses follow from the press time by plain arithmetic.
  logic [NB-1:0]  m_s1, m_s2, m_lvl, m_pulse;
  logic [DEB-1:0] m_hist [NB];
  int             m_press [NB];
  logic [NB-1:0]  mask = NB'(BTN_REPEAT_DEFAULT);
  int             cyc = 0;
  int             t0  = 0;
  int             plog [NB][$];
  int             rlog [NB][$];
  int             flog [NB][$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pulse = '0;
      for (int i = 0; i < NB; i++) m_hist[i] = '0;
    end else begin
      cyc++;
      for (int i = 0; i < NB; i++) begin
        logic nl;
        int   d;
        m_hist[i] = {m_hist[i][DEB-2:0], m_s2[i]};
        nl = m_lvl[i];
        if (m_hist[i] == {DEB{~m_lvl[i]}}) nl = ~m_lvl[i];
        m_pulse[i] = 1'b0;
        if (nl && !m_lvl[i]) begin
          m_pulse[i] = 1'b1;
          m_press[i] = cyc;
          rlog[i].push_back(cyc - t0);
        end else if (!nl && m_lvl[i]) begin
          flog[i].push_back(cyc - t0);
        end else if (nl && mask[i]) begin
          d = cyc - m_press[i];
          if (d == RD || (d > RD && (d - RD) % RP == 0)) m_pulse[i] = 1'b1;
        end
        if (m_pulse[i]) plog[i].push_back(cyc - t0);
        m_lvl[i] = nl;
      end
      m_s2 = m_s1;
      m_s1 = btn_raw;
    end
  end

  logic [NB-1:0] prev_pulse = '0;
  bit            cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("level", btn_level, m_lvl);
      check("pulse", btn_pulse, m_pulse);
      check("any_pulse", any_pulse, |m_pulse);
      check("pulse_back_to_back", btn_pulse & prev_pulse, '0);
      prev_pulse = btn_pulse;
    end
  end

  task automatic start_test();
    @(negedge clk);
    for (int i = 0; i < NB; i++) begin
      plog[i].delete(); rlog[i].delete(); flog[i].delete();
    end
    t0 = cyc + 1;
  endtask

  int exp_q[$];
  int any_cnt;
  logic [NB-1:0] hold;

  initial begin
    cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_level", btn_level, '0);
    check("reset_pulse", btn_pulse, '0);
    check("reset_any", any_pulse, '0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Reset mid-debounce: button held through a short reset pulse.
    start_test();
    for (int n = 0; n < 30; n++) begin
      btn_raw[0] = (n < 20);
      if (n == 4) begin
        #1 rst_n = 1'b0;
        #1;
        check("in_reset_level", btn_level, '0);
        check("in_reset_pulse", btn_pulse, '0);
        check("in_reset_any", any_pulse, '0);
        #1 rst_n = 1'b1;
      end
      @(negedge clk);
    end
    btn_raw = '0;
    repeat (10) @(negedge clk);
    exp_q = '{9};
    check_log("rst_mid_pulses", plog[0], exp_q);

    // Clean press on play/pause.
    start_test();
    for (int n = 0; n < 32; n++) begin
      btn_raw[0] = (n < 20);
      @(negedge clk);
    end
    exp_q = '{5};
    check_log("clean_pulses", plog[0], exp_q);
    check_log("clean_rise", rlog[0], exp_q);
    exp_q = '{25};
    check_log("clean_fall", flog[0], exp_q);

    // Bounce rejection.
    start_test();
    for (int n = 0; n < 16; n++) begin
      btn_raw[1] = (n <= 2) || (n == 4) || (n == 5);
      @(negedge clk);
    end
    exp_q.delete();
    check_log("bounce_pulses", plog[1], exp_q);
    check_log("bounce_rise", rlog[1], exp_q);
    check("bounce_level", btn_level[1], 1'b0);

    // Auto-repeat on volume up.
    start_test();
    for (int n = 0; n < 45; n++) begin
      btn_raw[BTN_VOL_UP] = (n <= 27);
      @(negedge clk);
    end
    exp_q = '{5, 15, 20, 25, 30};
    check_log("repeat_pulses", plog[BTN_VOL_UP], exp_q);
    exp_q = '{33};
    check_log("repeat_fall", flog[BTN_VOL_UP], exp_q);

    // Non-repeating hold plus two buttons rising together.
    start_test();
    any_cnt = 0;
    for (int n = 0; n < 55; n++) begin
      btn_raw[BTN_NEXT_SONG] = (n < 40);
      btn_raw[BTN_PASS_10S]  = (n < 10);
      btn_raw[BTN_PASS_30S]  = (n < 10);
      @(negedge clk);
      if (any_pulse) any_cnt++;
    end
    exp_q = '{5};
    check_log("next_song_pulses", plog[BTN_NEXT_SONG], exp_q);
    check_log("pass10_pulses", plog[BTN_PASS_10S], exp_q);
    check_log("pass30_pulses", plog[BTN_PASS_30S], exp_q);
    check("simul_any_cycles", any_cnt, 1);

    // Randomized bouncy holds with occasional asynchronous resets.
    btn_raw = '0;
    hold = '0;
    repeat (10) @(negedge clk);
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NB; i++) begin
        if ($urandom_range(0, 24) == 0) hold[i] = ~hold[i];
        btn_raw[i] = hold[i] ^ ($urandom_range(0, 9) == 0);
      end
      if ($urandom_range(0, 499) == 0) begin
        #1 rst_n = 1'b0;
        #($urandom_range(1, 3)) rst_n = 1'b1;
      end
      @(negedge clk);
    end
    btn_raw = '0;
    repeat (12) @(negedge clk);
    cmp_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
